// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: picks the next PC among mispredict recovery, predicted
// branches, resolved JALR targets and sequential advance, and runs the stall/flush FSM.
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          CNT_W        = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             inst_valid,
  input  logic             inst_length,
  input  logic             is_jalr,
  input  logic             foq_full,
  input  logic             need_branch,
  input  logic [31:0]      branch_addr,
  input  logic             predict_fail,
  input  logic [31:0]      fail_addr,
  input  logic             jalr_done,
  input  logic [31:0]      jalr_addr,
  output logic [31:0]      pc_out,
  output logic             fetch_en,
  output logic             flush_out,
  output logic [CNT_W-1:0] mispredict_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    RUN,
    WAIT_JALR,
    FLUSH
  } state_t;

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);

  state_t          state;
  logic [FC_W-1:0] flush_cnt;
  logic            advance;

  assign advance  = inst_valid & ~foq_full & (state == RUN);
  assign fetch_en = (state == RUN);

  // A mispredict overrides everything else in every state, so it is handled
  // ahead of the per-state decisions; counters stick at all-ones.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= RUN;
      pc_out         <= RESET_PC;
      flush_out      <= 1'b0;
      flush_cnt      <= '0;
      mispredict_cnt <= '0;
      redirect_cnt   <= '0;
    end else if (rdy_in) begin
      flush_out <= 1'b0;
      if (predict_fail) begin
        pc_out    <= fail_addr;
        flush_out <= 1'b1;
        flush_cnt <= FC_RELOAD;
        state     <= FLUSH;
        if (mispredict_cnt != '1)
          mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end else begin
        case (state)
          RUN: begin
            if (advance) begin
              if (is_jalr) begin
                state <= WAIT_JALR;
              end else if (need_branch) begin
                pc_out <= branch_addr;
                if (redirect_cnt != '1)
                  redirect_cnt <= redirect_cnt + CNT_W'(1);
              end else begin
                pc_out <= pc_out + (inst_length ? 32'd4 : 32'd2);
              end
            end
          end
          WAIT_JALR: begin
            if (jalr_done) begin
              pc_out <= jalr_addr & ~32'h1;
              state  <= RUN;
              if (redirect_cnt != '1)
                redirect_cnt <= redirect_cnt + CNT_W'(1);
            end
          end
          FLUSH: begin
            if (flush_cnt == '0)
              state <= RUN;
            else
              flush_cnt <= flush_cnt - FC_W'(1);
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl; counters are built 4 bits wide so
// saturation is reachable in a few cycles.
module tb_fetch_redirect_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, inst_valid, inst_length, is_jalr, foq_full;
  logic        need_branch, predict_fail, jalr_done;
  logic [31:0] branch_addr, fail_addr, jalr_addr;
  logic [31:0] pc_out;
  logic        fetch_en, flush_out;
  logic [3:0]  mispredict_cnt, redirect_cnt;

  int checks = 0;
  int failures = 0;

  fetch_redirect_ctrl #(
    .RESET_PC(32'h0), .FLUSH_CYCLES(2), .CNT_W(4)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .inst_valid(inst_valid), .inst_length(inst_length), .is_jalr(is_jalr),
    .foq_full(foq_full), .need_branch(need_branch), .branch_addr(branch_addr),
    .predict_fail(predict_fail), .fail_addr(fail_addr),
    .jalr_done(jalr_done), .jalr_addr(jalr_addr),
    .pc_out(pc_out), .fetch_en(fetch_en), .flush_out(flush_out),
    .mispredict_cnt(mispredict_cnt), .redirect_cnt(redirect_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    inst_valid = 0; inst_length = 0; is_jalr = 0; foq_full = 0;
    need_branch = 0; predict_fail = 0; jalr_done = 0;
    branch_addr = 32'hDEAD_BEE0; fail_addr = 32'hBAD0_0000; jalr_addr = 32'h0;
  endtask

  task automatic test_reset();
    rst_in = 1; rdy_in = 1; idle_inputs();
    tick(); tick();
    rst_in = 0;
    checks++; if (pc_out !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=%h", pc_out, 32'h0); end
    checks++; if (fetch_en !== 1'b1) begin failures++; $display("[TB] FAIL reset_fetch_en got=%b exp=1", fetch_en); end
    checks++; if (flush_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_flush got=%b exp=0", flush_out); end
    checks++; if (mispredict_cnt !== 4'd0 || redirect_cnt !== 4'd0) begin failures++; $display("[TB] FAIL reset_cnts got=%0d/%0d exp=0/0", mispredict_cnt, redirect_cnt); end
    tick();
    checks++; if (pc_out !== 32'h0) begin failures++; $display("[TB] FAIL idle_hold got=%h exp=%h", pc_out, 32'h0); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3] = '{32'h4, 32'h6, 32'hA};
    logic        lens   [3] = '{1'b1, 1'b0, 1'b1};
    inst_valid = 1;
    for (int i = 0; i < 3; i++) begin
      inst_length = lens[i];
      tick();
      checks++; if (pc_out !== exp_pc[i]) begin failures++; $display("[TB] FAIL seq_pc%0d got=%h exp=%h", i, pc_out, exp_pc[i]); end
    end
  endtask

  task automatic test_branch();
    inst_valid = 1; inst_length = 0; tick();   // 0xA -> 0xC
    inst_length = 1; tick();                   // 0xC -> 0x10
    checks++; if (pc_out !== 32'h10) begin failures++; $display("[TB] FAIL br_setup got=%h exp=%h", pc_out, 32'h10); end
    need_branch = 1; branch_addr = 32'h40;
    tick();
    need_branch = 0;
    checks++; if (pc_out !== 32'h40) begin failures++; $display("[TB] FAIL br_pc got=%h exp=%h", pc_out, 32'h40); end
    checks++; if (redirect_cnt !== 4'd1) begin failures++; $display("[TB] FAIL br_redirect got=%0d exp=1", redirect_cnt); end
  endtask

  task automatic test_foq_full();
    inst_valid = 1; inst_length = 1; foq_full = 1; need_branch = 1; branch_addr = 32'h900;
    tick(); tick();
    checks++; if (pc_out !== 32'h40) begin failures++; $display("[TB] FAIL foq_hold got=%h exp=%h", pc_out, 32'h40); end
    checks++; if (redirect_cnt !== 4'd1) begin failures++; $display("[TB] FAIL foq_redirect got=%0d exp=1", redirect_cnt); end
    foq_full = 0; need_branch = 0;
    tick();
    checks++; if (pc_out !== 32'h44) begin failures++; $display("[TB] FAIL foq_release got=%h exp=%h", pc_out, 32'h44); end
  endtask

  task automatic test_jalr();
    inst_valid = 1; need_branch = 1; branch_addr = 32'h20;
    tick();
    need_branch = 0; is_jalr = 1;
    tick();
    is_jalr = 0; inst_valid = 0;
    checks++; if (fetch_en !== 1'b0 || pc_out !== 32'h20) begin failures++; $display("[TB] FAIL jalr_wait got=%b/%h exp=0/%h", fetch_en, pc_out, 32'h20); end
    inst_valid = 1; need_branch = 1; branch_addr = 32'h700;
    tick();
    inst_valid = 0; need_branch = 0;
    checks++; if (fetch_en !== 1'b0 || pc_out !== 32'h20) begin failures++; $display("[TB] FAIL jalr_stall got=%b/%h exp=0/%h", fetch_en, pc_out, 32'h20); end
    jalr_done = 1; jalr_addr = 32'h101;
    tick();
    jalr_done = 0;
    checks++; if (pc_out !== 32'h100) begin failures++; $display("[TB] FAIL jalr_pc got=%h exp=%h", pc_out, 32'h100); end
    checks++; if (fetch_en !== 1'b1) begin failures++; $display("[TB] FAIL jalr_run got=%b exp=1", fetch_en); end
    checks++; if (redirect_cnt !== 4'd3) begin failures++; $display("[TB] FAIL jalr_redirect got=%0d exp=3", redirect_cnt); end
  endtask

  task automatic test_mispredict();
    predict_fail = 1; fail_addr = 32'h80; inst_valid = 1; need_branch = 1; branch_addr = 32'h200;
    tick();                                       // T+1
    predict_fail = 0; inst_valid = 0; need_branch = 0;
    checks++; if (pc_out !== 32'h80) begin failures++; $display("[TB] FAIL mp_pc got=%h exp=%h", pc_out, 32'h80); end
    checks++; if (flush_out !== 1'b1 || fetch_en !== 1'b0) begin failures++; $display("[TB] FAIL mp_t1 flush/fetch got=%b/%b exp=1/0", flush_out, fetch_en); end
    checks++; if (mispredict_cnt !== 4'd1 || redirect_cnt !== 4'd3) begin failures++; $display("[TB] FAIL mp_cnts got=%0d/%0d exp=1/3", mispredict_cnt, redirect_cnt); end
    tick();                                       // T+2
    checks++; if (flush_out !== 1'b0 || fetch_en !== 1'b0) begin failures++; $display("[TB] FAIL mp_t2 flush/fetch got=%b/%b exp=0/0", flush_out, fetch_en); end
    tick();                                       // T+3
    checks++; if (fetch_en !== 1'b1 || pc_out !== 32'h80) begin failures++; $display("[TB] FAIL mp_t3 fetch/pc got=%b/%h exp=1/%h", fetch_en, pc_out, 32'h80); end
  endtask

  task automatic test_back_to_back();
    predict_fail = 1; fail_addr = 32'h90;
    tick();                                       // T+1
    predict_fail = 0;
    tick();                                       // T+2
    predict_fail = 1; fail_addr = 32'hC0; jalr_done = 1; jalr_addr = 32'h555;
    tick();
    predict_fail = 0; jalr_done = 0;
    checks++; if (pc_out !== 32'hC0 || flush_out !== 1'b1) begin failures++; $display("[TB] FAIL b2b_restart pc/flush got=%h/%b exp=%h/1", pc_out, flush_out, 32'hC0); end
    checks++; if (mispredict_cnt !== 4'd3) begin failures++; $display("[TB] FAIL b2b_mcnt got=%0d exp=3", mispredict_cnt); end
    tick();
    checks++; if (fetch_en !== 1'b0 || flush_out !== 1'b0) begin failures++; $display("[TB] FAIL b2b_window fetch/flush got=%b/%b exp=0/0", fetch_en, flush_out); end
    tick();
    checks++; if (fetch_en !== 1'b1 || pc_out !== 32'hC0) begin failures++; $display("[TB] FAIL b2b_resume fetch/pc got=%b/%h exp=1/%h", fetch_en, pc_out, 32'hC0); end
  endtask

  task automatic test_jalr_dropped();
    inst_valid = 1; is_jalr = 1;
    tick();
    inst_valid = 0; is_jalr = 0;
    predict_fail = 1; fail_addr = 32'h300; jalr_done = 1; jalr_addr = 32'h500;
    tick();
    predict_fail = 0; jalr_done = 0;
    checks++; if (pc_out !== 32'h300 || flush_out !== 1'b1) begin failures++; $display("[TB] FAIL jdrop pc/flush got=%h/%b exp=%h/1", pc_out, flush_out, 32'h300); end
    checks++; if (mispredict_cnt !== 4'd4 || redirect_cnt !== 4'd3) begin failures++; $display("[TB] FAIL jdrop_cnts got=%0d/%0d exp=4/3", mispredict_cnt, redirect_cnt); end
    tick(); tick();
    checks++; if (fetch_en !== 1'b1 || pc_out !== 32'h300) begin failures++; $display("[TB] FAIL jdrop_resume fetch/pc got=%b/%h exp=1/%h", fetch_en, pc_out, 32'h300); end
  endtask

  task automatic test_freeze();
    predict_fail = 1; fail_addr = 32'h400;
    tick();
    predict_fail = 0;
    rdy_in = 0; predict_fail = 1; fail_addr = 32'h999; jalr_done = 1; jalr_addr = 32'h777;
    tick(); tick(); tick();
    checks++; if (flush_out !== 1'b1 || fetch_en !== 1'b0) begin failures++; $display("[TB] FAIL frz flush/fetch got=%b/%b exp=1/0", flush_out, fetch_en); end
    checks++; if (pc_out !== 32'h400 || mispredict_cnt !== 4'd5) begin failures++; $display("[TB] FAIL frz pc/mcnt got=%h/%0d exp=%h/5", pc_out, mispredict_cnt, 32'h400); end
    rdy_in = 1; predict_fail = 0; jalr_done = 0;
    tick();
    checks++; if (flush_out !== 1'b0 || fetch_en !== 1'b0) begin failures++; $display("[TB] FAIL frz_cnt_kept flush/fetch got=%b/%b exp=0/0", flush_out, fetch_en); end
    tick();
    checks++; if (fetch_en !== 1'b1) begin failures++; $display("[TB] FAIL frz_resume got=%b exp=1", fetch_en); end
  endtask

  task automatic test_wrap();
    inst_valid = 1; need_branch = 1; branch_addr = 32'hFFFF_FFFE;
    tick();
    need_branch = 0; inst_length = 1;
    tick();
    inst_valid = 0;
    checks++; if (pc_out !== 32'h2) begin failures++; $display("[TB] FAIL wrap_pc got=%h exp=%h", pc_out, 32'h2); end
    checks++; if (redirect_cnt !== 4'd4) begin failures++; $display("[TB] FAIL wrap_redirect got=%0d exp=4", redirect_cnt); end
  endtask

  task automatic test_saturation();
    inst_valid = 1; need_branch = 1;
    for (int i = 0; i < 20; i++) begin
      branch_addr = 32'h1000 + 32'(i * 4);
      tick();
    end
    inst_valid = 0; need_branch = 0;
    checks++; if (redirect_cnt !== 4'd15) begin failures++; $display("[TB] FAIL sat_redirect got=%0d exp=15", redirect_cnt); end
    checks++; if (pc_out !== 32'h104C) begin failures++; $display("[TB] FAIL sat_pc got=%h exp=%h", pc_out, 32'h104C); end
  endtask

  task automatic test_reset_mid_flush();
    predict_fail = 1; fail_addr = 32'h600;
    tick();
    predict_fail = 0; rst_in = 1;
    tick();
    rst_in = 0;
    checks++; if (pc_out !== 32'h0 || fetch_en !== 1'b1 || flush_out !== 1'b0) begin failures++; $display("[TB] FAIL rstflush pc/fetch/flush got=%h/%b/%b exp=0/1/0", pc_out, fetch_en, flush_out); end
    checks++; if (mispredict_cnt !== 4'd0 || redirect_cnt !== 4'd0) begin failures++; $display("[TB] FAIL rstflush_cnts got=%0d/%0d exp=0/0", mispredict_cnt, redirect_cnt); end
    inst_valid = 1; inst_length = 1;
    tick();
    inst_valid = 0;
    checks++; if (pc_out !== 32'h4) begin failures++; $display("[TB] FAIL rstflush_adv got=%h exp=%h", pc_out, 32'h4); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_foq_full();
    test_jalr();
    test_mispredict();
    test_back_to_back();
    test_jalr_dropped();
    test_freeze();
    test_wrap();
    test_saturation();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
